// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter state encodings
// and the conditional-branch funct3 codes used by the branch unit.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_state_e;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Upper counter bit carries the direction.
    function automatic logic ctr_predicts_taken(input ctr_state_e c);
        return c[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating up/down counter step: counts toward ST on taken,
// toward SNT on not-taken, never wrapping.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_state_e cur,
    input  logic       taken,
    output ctr_state_e next
);

    always_comb begin
        next = cur;
        case (cur)
            CTR_SNT: next = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: next = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  next = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  next = taken ? CTR_ST  : CTR_WT;
            default: next = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB with 2-bit counters, zero-latency lookup, and
// saturating branch / misprediction performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pred_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    output logic              mispredict,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [IDX_W-1:0]   pred_idx, upd_idx;
    logic [TAG_W-1:0]   pred_tag, upd_tag;
    logic [ENTRIES-1:0] valid_reg;
    logic [ENTRIES-1:0] entry_sel;
    ctr_state_e         ctr_reg [ENTRIES];
    ctr_state_e         ctr_next;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic               upd_hit;
    logic [PERF_W-1:0]  perf_branches_reg, perf_mispredicts_reg;
    logic               unused_upd_pc_bits;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign pred_tag = pred_pc[31:IDX_W+2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign upd_tag  = upd_pc[31:IDX_W+2];
    assign unused_upd_pc_bits = ^upd_pc[1:0];

    assign upd_hit = valid_reg[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_sel
            assign entry_sel[gi] = upd_valid && (upd_idx == IDX_W'(gi));
        end
    endgenerate

    sat_counter2 u_sat_counter2 (
        .cur   (ctr_reg[upd_idx]),
        .taken (upd_taken),
        .next  (ctr_next)
    );

    // Valid and counter state reset; an update coinciding with reset is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_reg[i] <= CTR_WNT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (entry_sel[i]) begin
                    if (upd_hit) begin
                        ctr_reg[i] <= ctr_next;
                    end else if (upd_taken) begin
                        valid_reg[i] <= 1'b1;
                        ctr_reg[i]   <= CTR_WT;
                    end
                end
            end
        end
    end

    // Tag/target need no reset: they are meaningless while valid is clear.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_reg    <= '0;
            perf_mispredicts_reg <= '0;
        end else begin
            if (upd_valid && !(&perf_branches_reg)) begin
                perf_branches_reg <= perf_branches_reg + PERF_W'(1);
            end
            if (mispredict && !(&perf_mispredicts_reg)) begin
                perf_mispredicts_reg <= perf_mispredicts_reg + PERF_W'(1);
            end
        end
    end

    // Lookup sees pre-update state when it collides with an update.
    assign pred_hit    = valid_reg[pred_idx] && (tag_mem[pred_idx] == pred_tag);
    assign pred_taken  = pred_hit && ctr_predicts_taken(ctr_reg[pred_idx]);
    assign pred_target = pred_taken ? target_mem[pred_idx] : pred_pc + 32'd4;

    assign mispredict       = upd_valid && (upd_taken != upd_pred_taken);
    assign perf_branches    = perf_branches_reg;
    assign perf_mispredicts = perf_mispredicts_reg;

endmodule
